// File: rtl/ula_pkg.sv
// ula_pkg: shared constants for the 4-bit ULA datapath.
//   ULA_WIDTH_DEF : default operand/result width
//   OP_*          : 3-bit operation selector codes
//   ula_is_arith  : true for selector codes that go through the adder/subtractor
package ula_pkg;

    localparam int ULA_WIDTH_DEF = 4;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

    function automatic logic ula_is_arith(input logic [2:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/ula_addsub.sv
// ula_addsub: combinational WIDTH-bit adder/subtractor.
//   a_i, b_i : unsigned operands
//   sub_i    : 0 = a + b, 1 = a - b (b inverted, carry-in 1)
//   sum_o    : result truncated to WIDTH bits
//   carry_o  : carry-out for add, borrow (a < b) for subtract
module ula_addsub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = sub_i ? ~b_i : b_i;
    assign full  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
    assign sum_o = full[WIDTH-1:0];

    // With inverted B and carry-in 1 the carry-out means "no borrow",
    // so it is flipped to report borrow directly.
    assign carry_o = sub_i ? ~full[WIDTH] : full[WIDTH];

endmodule

// File: rtl/ula_4bit.sv
// ula_4bit: registered 4-bit arithmetic/logic unit.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : A/B/seletor valid this cycle
//   A, B      : unsigned operands
//   seletor   : operation select (see ula_pkg OP_*; 110/111 give zero)
//   resultado : registered result
//   out_valid : one-cycle pulse after each accepted operation
//   carry     : registered carry/borrow  (ULA_FLAGS_EN only)
//   zero      : registered zero flag     (ULA_FLAGS_EN only)
// Build option: define ULA_FLAGS_EN to add the carry/zero flag registers.
module ula_4bit
    import ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       seletor,
    output logic [WIDTH-1:0] resultado,
`ifdef ULA_FLAGS_EN
    output logic             carry,
    output logic             zero,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] addsub_sum;
    logic [WIDTH-1:0] resultado_d;
    logic [WIDTH-1:0] resultado_q;
    logic             out_valid_q;

`ifdef ULA_FLAGS_EN
    logic addsub_carry;
    logic carry_d;
    logic carry_q;
    logic zero_d;
    logic zero_q;
`else
    logic addsub_carry_unused;
`endif

    ula_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i     (A),
        .b_i     (B),
        .sub_i   (seletor == OP_SUB),
        .sum_o   (addsub_sum),
`ifdef ULA_FLAGS_EN
        .carry_o (addsub_carry)
`else
        .carry_o (addsub_carry_unused)
`endif
    );

    always_comb begin
        resultado_d = '0;
        case (seletor)
            OP_AND:  resultado_d = A & B;
            OP_OR:   resultado_d = A | B;
            OP_NOT:  resultado_d = ~A;
            OP_NAND: resultado_d = ~(A & B);
            OP_ADD,
            OP_SUB:  resultado_d = addsub_sum;
            default: resultado_d = '0;
        endcase
    end

`ifdef ULA_FLAGS_EN
    // Logic ops and the unused codes always report carry 0.
    assign carry_d = ula_is_arith(seletor) ? addsub_carry : 1'b0;
    assign zero_d  = (resultado_d == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultado_q <= '0;
            out_valid_q <= 1'b0;
`ifdef ULA_FLAGS_EN
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                resultado_q <= resultado_d;
`ifdef ULA_FLAGS_EN
                carry_q     <= carry_d;
                zero_q      <= zero_d;
`endif
            end
        end
    end

    assign resultado = resultado_q;
    assign out_valid = out_valid_q;
`ifdef ULA_FLAGS_EN
    assign carry     = carry_q;
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_ula_4bit.sv
module tb_ula_4bit;

    localparam int W    = 4;
    localparam int MOD  = 1 << W;
    localparam int MASK = MOD - 1;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] A        = '0;
    logic [W-1:0] B        = '0;
    logic [2:0]   seletor  = '0;
    logic [W-1:0] resultado;
    logic         out_valid;
`ifdef ULA_FLAGS_EN
    logic         carry;
    logic         zero;
`endif

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ula_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .seletor   (seletor),
        .resultado (resultado),
`ifdef ULA_FLAGS_EN
        .carry     (carry),
        .zero      (zero),
`endif
        .out_valid (out_valid)
    );

    // Reference: plain integer arithmetic from the operation table.
    function automatic logic [W:0] ref_op(input int a, input int b, input int sel);
        int r;
        int c;
        logic [W:0] ret;
        r = 0;
        c = 0;
        case (sel)
            0: r = a & b;
            1: r = a | b;
            2: r = MASK - a;
            3: r = MASK - (a & b);
            4: begin r = (a + b) % MOD; c = ((a + b) >= MOD) ? 1 : 0; end
            5: begin r = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
            default: begin r = 0; c = 0; end
        endcase
        ret[W-1:0] = r[W-1:0];
        ret[W]     = c[0];
        return ret;
    endfunction

    logic [W-1:0] m_res;
    logic         m_valid;
    logic         m_carry;
    logic         m_zero;
    logic [W:0]   m_next;

    assign m_next = ref_op(int'(A), int'(B), int'(seletor));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res   <= '0;
            m_valid <= 1'b0;
            m_carry <= 1'b0;
            m_zero  <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                m_res   <= m_next[W-1:0];
                m_carry <= m_next[W];
                m_zero  <= (m_next[W-1:0] == '0);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_res", int'(resultado), int'(m_res));
            chk("model_valid", int'(out_valid), int'(m_valid));
`ifdef ULA_FLAGS_EN
            chk("model_carry", int'(carry), int'(m_carry));
            chk("model_zero", int'(zero), int'(m_zero));
`endif
        end
    end

    // Drive one valid operation and check the literal result just after the edge.
    task automatic op_chk(input int a, input int b, input int sel,
                          input int exp_res, input int exp_c);
        @(negedge clk);
        A        = a[W-1:0];
        B        = b[W-1:0];
        seletor  = sel[2:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("lit_res", int'(resultado), exp_res);
        chk("lit_valid", int'(out_valid), 1);
`ifdef ULA_FLAGS_EN
        chk("lit_carry", int'(carry), exp_c);
        chk("lit_zero", int'(zero), (exp_res == 0) ? 1 : 0);
`else
        if (exp_c < 0) $display("note: negative carry expectation");
`endif
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        seletor  = 3'($urandom);
    endtask

    initial begin
        // Asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("rst_res", int'(resultado), 0);
        chk("rst_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (2) idle_cycle();
        @(posedge clk);
        #1;
        chk("post_rst_res", int'(resultado), 0);
        chk("post_rst_valid", int'(out_valid), 0);

        // A=1010 B=0110
        op_chk(4'b1010, 4'b0110, 0, 4'b0010, 0);
        op_chk(4'b1010, 4'b0110, 1, 4'b1110, 0);
        op_chk(4'b1010, 4'b0110, 2, 4'b0101, 0);
        op_chk(4'b1010, 4'b0110, 3, 4'b1101, 0);
        op_chk(4'b1010, 4'b0110, 4, 4'b0000, 1);
        op_chk(4'b1010, 4'b0110, 5, 4'b0100, 0);
        // A=1111 B=0001
        op_chk(4'b1111, 4'b0001, 0, 4'b0001, 0);
        op_chk(4'b1111, 4'b0001, 1, 4'b1111, 0);
        op_chk(4'b1111, 4'b0001, 2, 4'b0000, 0);
        op_chk(4'b1111, 4'b0001, 3, 4'b1110, 0);
        op_chk(4'b1111, 4'b0001, 4, 4'b0000, 1);
        op_chk(4'b1111, 4'b0001, 5, 4'b1110, 0);
        // A=0011 B=1101
        op_chk(4'b0011, 4'b1101, 0, 4'b0001, 0);
        op_chk(4'b0011, 4'b1101, 1, 4'b1111, 0);
        op_chk(4'b0011, 4'b1101, 2, 4'b1100, 0);
        op_chk(4'b0011, 4'b1101, 3, 4'b1110, 0);
        op_chk(4'b0011, 4'b1101, 4, 4'b0000, 1);
        op_chk(4'b0011, 4'b1101, 5, 4'b0110, 1);
        // Unused codes
        op_chk(4'b1010, 4'b0110, 6, 4'b0000, 0);
        op_chk(4'b1010, 4'b0110, 7, 4'b0000, 0);

        // Hold while in_valid is low
        op_chk(4'b1010, 4'b0110, 5, 4'b0100, 0);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            @(posedge clk);
            #1;
            chk("hold_res", int'(resultado), 4'b0100);
            chk("hold_valid", int'(out_valid), 0);
        end
        op_chk(4'b0001, 4'b0010, 4, 4'b0011, 0);

        // Reset mid-stream discards the pending capture
        @(negedge clk);
        A = 4'b0101; B = 4'b0011; seletor = 3'b100; in_valid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_res", int'(resultado), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_hold_res", int'(resultado), 0);
        chk("mid_rst_hold_valid", int'(out_valid), 0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            A        = W'($urandom);
            B        = W'($urandom);
            seletor  = 3'($urandom_range(7, 0));
            in_valid = ($urandom_range(3, 0) != 0);
        end
        idle_cycle();
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
